// File: rtl/swervolf_wb_initiator.sv
// Single-outstanding Wishbone initiator: accepts one command, runs one bus
// cycle (ack, error or timeout), then holds the response until consumed.
module swervolf_wb_initiator #(
  parameter int ADR_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [ADR_W-1:0] i_cmd_adr,
  input  logic [31:0]      i_cmd_dat,
  input  logic [3:0]       i_cmd_sel,
  input  logic             i_cmd_we,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_rdt,
  output logic             o_rsp_err,
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [31:0]      o_wb_dat,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic [31:0]      i_wb_rdt,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  output logic             o_busy
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_cmd_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_wb_cyc    = 1'b0;
    o_wb_stb    = 1'b0;
    o_busy      = 1'b1;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (i_cmd_valid) state_nxt = BUS;
      end
      BUS: begin
        o_wb_cyc = 1'b1;
        o_wb_stb = 1'b1;
        if (i_wb_ack || i_wb_err || timeout_hit) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter only advances on idle bus cycles and stops at TIMEOUT-1, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_adr  <= '0;
      o_wb_dat  <= '0;
      o_wb_sel  <= '0;
      o_wb_we   <= 1'b0;
      o_rsp_rdt <= '0;
      o_rsp_err <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (i_cmd_valid) begin
          o_wb_adr <= i_cmd_adr;
          o_wb_dat <= i_cmd_dat;
          o_wb_sel <= i_cmd_sel;
          o_wb_we  <= i_cmd_we;
          cnt      <= '0;
        end
        BUS: begin
          if (i_wb_err) begin
            o_rsp_rdt <= '0;
            o_rsp_err <= 1'b1;
          end else if (i_wb_ack) begin
            o_rsp_rdt <= o_wb_we ? 32'd0 : i_wb_rdt;
            o_rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            o_rsp_rdt <= '0;
            o_rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swervolf_wb_initiator.sv
// Randomized scoreboard bench: driver pushes expected responses, a slave model
// answers bus cycles, and a monitor checks responses, latency and stability.
module tb_swervolf_wb_initiator;
  localparam int ADR_W   = 6;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             i_rst, i_cmd_valid, i_cmd_we, i_rsp_ready, i_wb_ack, i_wb_err;
  logic [ADR_W-1:0] i_cmd_adr;
  logic [31:0]      i_cmd_dat, i_wb_rdt;
  logic [3:0]       i_cmd_sel;
  logic             o_cmd_ready, o_rsp_valid, o_rsp_err, o_wb_we, o_wb_cyc, o_wb_stb, o_busy;
  logic [31:0]      o_rsp_rdt, o_wb_dat;
  logic [ADR_W-1:0] o_wb_adr;
  logic [3:0]       o_wb_sel;

  always #5 clk = ~clk;

  swervolf_wb_initiator #(.ADR_W(ADR_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_adr(i_cmd_adr),
    .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel), .i_cmd_we(i_cmd_we),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdt(o_rsp_rdt),
    .o_rsp_err(o_rsp_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack),
    .i_wb_err(i_wb_err), .o_busy(o_busy)
  );

  // kind: 0 = ack, 1 = err, 2 = ack+err; d = stb cycle index (0-based) of the reply
  typedef struct {
    logic [ADR_W-1:0] adr;
    logic [31:0]      dat;
    logic [3:0]       sel;
    logic             we;
    logic [31:0]      rdata;
    int               d;
    int               kind;
  } cfg_t;

  typedef struct {
    logic [31:0] rdt;
    logic        err;
    int          t;
  } exp_t;

  cfg_t cfgq[$];
  exp_t sbq[$];
  int   cyc_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc_n);
    end
  endtask

  // Reference model: the reply lands only if it comes before the timeout budget runs out.
  function automatic exp_t model(input cfg_t c, input int t_hs);
    exp_t e;
    if (c.d < TIMEOUT) begin
      e.err = (c.kind != 0);
      e.rdt = (e.err || c.we) ? 32'd0 : c.rdata;
      e.t   = t_hs + 2 + c.d;
    end else begin
      e.err = 1'b1;
      e.rdt = 32'd0;
      e.t   = t_hs + 2 + TIMEOUT - 1;
    end
    return e;
  endfunction

  function automatic int exp_stb(input cfg_t c);
    return (c.d < TIMEOUT) ? c.d + 1 : TIMEOUT;
  endfunction

  function automatic cfg_t mk(input logic [ADR_W-1:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic we,
                              input logic [31:0] rdata, input int d, input int kind);
    cfg_t c;
    c.adr = adr; c.dat = dat; c.sel = sel; c.we = we;
    c.rdata = rdata; c.d = d; c.kind = kind;
    return c;
  endfunction

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic issue(input cfg_t c, input bit expect_rsp);
    int k;
    i_cmd_adr = c.adr; i_cmd_dat = c.dat; i_cmd_sel = c.sel; i_cmd_we = c.we;
    i_cmd_valid = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      if (o_cmd_ready) break;
      k++;
      if (k > 200) begin
        chk("cmd_accept_timeout", 32'd0, 32'd1);
        i_cmd_valid = 1'b0;
        return;
      end
    end
    cfgq.push_back(c);
    if (expect_rsp) sbq.push_back(model(c, cyc_n));
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
    i_cmd_adr = ADR_W'($urandom); i_cmd_dat = $urandom;
    i_cmd_sel = 4'($urandom);     i_cmd_we  = 1'($urandom);
  endtask

  // Slave: replies per the popped config; drives junk ack/err whenever stb is low.
  initial begin
    cfg_t cur;
    int   n;
    bit   active;
    active = 1'b0; n = 0;
    cur = mk('0, '0, '0, 1'b0, '0, 0, 0);
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_rdt = '0;
    forever begin
      @(negedge clk);
      if (i_rst === 1'b1) begin
        active = 1'b0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0;
      end else if (o_wb_stb === 1'b1) begin
        if (!active) begin
          if (cfgq.size() == 0) chk("stb_unexpected", 32'd1, 32'd0);
          else cur = cfgq.pop_front();
          active = 1'b1; n = 0;
        end
        chk("wb_cyc", 32'(o_wb_cyc), 32'd1);
        chk("wb_adr", 32'(o_wb_adr), 32'(cur.adr));
        chk("wb_dat", o_wb_dat, cur.dat);
        chk("wb_sel_we", {27'd0, o_wb_we, o_wb_sel}, {27'd0, cur.we, cur.sel});
        i_wb_ack = (n == cur.d) && (cur.kind != 1);
        i_wb_err = (n == cur.d) && (cur.kind != 0);
        i_wb_rdt = (n == cur.d) ? cur.rdata : $urandom;
        n++;
      end else begin
        if (active) begin
          chk("stb_cycles", 32'(n), 32'(exp_stb(cur)));
          active = 1'b0;
        end
        i_wb_ack = 1'($urandom); i_wb_err = 1'($urandom); i_wb_rdt = $urandom;
      end
    end
  end

  // Response monitor and consumer.
  initial begin
    exp_t        e;
    bit          pending, hs_prev;
    int          hold, nrsp;
    logic [31:0] h_rdt;
    logic        h_err;
    pending = 1'b0; hs_prev = 1'b0; hold = 0; nrsp = 0;
    h_rdt = '0; h_err = 1'b0;
    i_rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (i_rst !== 1'b0) begin
        pending = 1'b0; hs_prev = 1'b0; i_rsp_ready = 1'b0;
        continue;
      end
      if (hs_prev) chk("cmd_ready_after_rsp", 32'(o_cmd_ready), 32'd1);
      if (o_rsp_valid === 1'b1) begin
        chk("cmd_ready_in_resp", 32'(o_cmd_ready), 32'd0);
        if (!pending) begin
          if (sbq.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
          else begin
            e = sbq.pop_front();
            chk("rsp_rdt", o_rsp_rdt, e.rdt);
            chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
            chk("rsp_latency", 32'(cyc_n), 32'(e.t));
          end
          h_rdt = o_rsp_rdt; h_err = o_rsp_err;
          pending = 1'b1;
          hold = (nrsp < 4) ? 5 : $urandom_range(0, 3);
          nrsp++;
        end else begin
          chk("rsp_rdt_stable", o_rsp_rdt, h_rdt);
          chk("rsp_err_stable", 32'(o_rsp_err), 32'(h_err));
        end
        if (hold > 0) begin
          hold--;
          i_rsp_ready = 1'b0;
        end else i_rsp_ready = 1'b1;
      end else begin
        pending = 1'b0;
        i_rsp_ready = 1'($urandom);
      end
      hs_prev = (o_rsp_valid === 1'b1) && i_rsp_ready;
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, d, kind, k;
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_adr = '0; i_cmd_dat = '0;
    i_cmd_sel = '0; i_cmd_we = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cyc_stb_we", {29'd0, o_wb_cyc, o_wb_stb, o_wb_we}, 32'd0);
    chk("rst_adr", 32'(o_wb_adr), 32'd0);
    chk("rst_dat", o_wb_dat, 32'd0);
    chk("rst_sel", 32'(o_wb_sel), 32'd0);
    chk("rst_rsp", {30'd0, o_rsp_valid, o_rsp_err}, 32'd0);
    chk("rst_rdt", o_rsp_rdt, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 32'(o_cmd_ready), 32'd1);
    @(posedge clk); #1;

    // Reset pulsed in the second bus cycle of a read the slave never answers.
    issue(mk(6'h10, 32'h0, 4'hF, 1'b0, 32'h0, 1000, 0), 1'b0);
    @(negedge clk);
    chk("abort_cyc_before", 32'(o_wb_cyc), 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("abort_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_cmd_ready", 32'(o_cmd_ready), 32'd1);
    cfgq.delete();
    @(posedge clk); #1;

    issue(mk(6'h3C, 32'h12345678, 4'hF, 1'b1, 32'hA5A5A5A5, 1, 0), 1'b1);
    issue(mk(6'h00, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 1, 0), 1'b1);
    issue(mk(6'h04, 32'h0, 4'hF, 1'b0, 32'h11111111, 1000, 0), 1'b1);
    issue(mk(6'h08, 32'h0, 4'hF, 1'b0, 32'h22222222, 2, 2), 1'b1);
    issue(mk(6'h0C, 32'h0, 4'h3, 1'b0, 32'h33333333, 0, 1), 1'b1);
    issue(mk(6'h10, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, TIMEOUT - 1, 0), 1'b1);
    issue(mk(6'h14, 32'h0, 4'hF, 1'b0, 32'h44444444, TIMEOUT, 0), 1'b1);
    issue(mk(6'h18, 32'h0, 4'hF, 1'b0, 32'h55555555, 0, 0), 1'b1);

    for (int i = 0; i < 150; i++) begin
      r    = $urandom_range(0, 7);
      kind = (r < 6) ? 0 : r - 5;
      d    = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 24) : $urandom_range(0, 3);
      issue(mk(ADR_W'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom, d, kind), 1'b1);
    end

    k = 0;
    while ((sbq.size() != 0 || o_rsp_valid === 1'b1) && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_left", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/swervolf_wb_initiator.md
SWERVOLF_WB_INITIATOR -- requirements
Module: swervolf_wb_initiator

Interface
REQ-001 SHALL have parameter ADR_W, default 6, Wishbone byte-address width matching the system-controller window.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum bus cycles (2..65535) with stb high before an abort.
REQ-003 SHALL have a single clock i_clk and a synchronous, active-high reset i_rst.
REQ-004 Ports (name, direction, width, meaning):
- i_clk  in  1  clock
- i_rst  in  1  sync active-high reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  command accepted when high with valid
- i_cmd_adr  in  ADR_W  byte address
- i_cmd_dat  in  32  write data
- i_cmd_sel  in  4  byte enables
- i_cmd_we  in  1  1=write, 0=read
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  response consumed
- o_rsp_rdt  out  32  read data
- o_rsp_err  out  1  bus error or timeout
- o_wb_adr  out  ADR_W  Wishbone address
- o_wb_dat  out  32  Wishbone write data
- o_wb_sel  out  4  Wishbone byte select
- o_wb_we  out  1  Wishbone write enable
- o_wb_cyc  out  1  Wishbone cycle
- o_wb_stb  out  1  Wishbone strobe
- i_wb_rdt  in  32  Wishbone read data
- i_wb_ack  in  1  Wishbone acknowledge
- i_wb_err  in  1  Wishbone error
- o_busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement the states IDLE, BUS and RESP; o_cmd_ready SHALL be 1 only in IDLE.
REQ-006 On a handshake (i_cmd_valid & o_cmd_ready), SHALL register adr/dat/sel/we onto the o_wb_* outputs and enter BUS on the next edge.
REQ-007 In BUS, o_wb_cyc = o_wb_stb = 1; o_wb_adr/dat/sel/we SHALL remain stable until the cycle ends.
REQ-008 A BUS-cycle counter SHALL clear on entry to BUS and increment each BUS cycle that has neither i_wb_ack nor i_wb_err.
REQ-009 In BUS with i_wb_ack=1 and i_wb_err=0: next edge cyc/stb=0, o_rsp_rdt = i_wb_rdt for a read or 0 for a write, o_rsp_err=0, enter RESP.
REQ-010 In BUS with i_wb_err=1 (with or without ack): next edge cyc/stb=0, o_rsp_rdt=0, o_rsp_err=1, enter RESP; err wins over ack.
REQ-011 In BUS with counter == TIMEOUT-1 and no ack/err: next edge cyc/stb=0, o_rsp_rdt=0, o_rsp_err=1, enter RESP; stb is high for exactly TIMEOUT cycles.
REQ-012 If ack arrives in the same cycle the timeout would fire, SHALL complete normally per REQ-009.
REQ-013 In RESP, o_rsp_valid=1 with rdt/err held stable until i_rsp_ready=1; next edge enter IDLE with o_rsp_valid=0.
REQ-014 A new command SHALL NOT be accepted in the cycle of the response handshake; o_cmd_ready SHALL rise on the following cycle.
REQ-015 i_wb_ack/i_wb_err outside BUS SHALL be ignored without affecting state or outputs.
REQ-016 Minimum latency SHALL be: command handshake at T, stb at T+1, ack at T+2 (single-cycle slave), o_rsp_valid at T+3.
REQ-017 The counter SHALL be ceil(log2(TIMEOUT)) bits wide and SHALL never wrap within one transaction.

Reset
REQ-018 On i_rst=1 at an edge, SHALL enter IDLE with o_wb_cyc=o_wb_stb=o_wb_we=0, o_wb_adr/dat/sel=0, o_rsp_valid=0, o_rsp_rdt=0, o_rsp_err=0, o_busy=0 and counter=0.
REQ-019 Reset during BUS or RESP SHALL abort silently: cyc drops on that edge and no response is produced.
REQ-020 Following release of reset, o_cmd_ready SHALL be 1 in the first cycle.

Verification
REQ-021 Write adr=0x3C, dat=0x12345678, sel=0xF to a slave that acks one cycle after cyc -> cyc high for 2 cycles, we=1 throughout, o_rsp_valid with err=0 and rdt=0.
REQ-022 Read adr=0x00 with the slave returning 0xDEADBEEF on ack -> o_rsp_rdt=0xDEADBEEF, err=0, response at handshake+3.
REQ-023 Read with no ack, TIMEOUT=16 -> stb high for exactly 16 cycles, then o_rsp_err=1, rdt=0.
REQ-024 Slave asserts ack and err together -> o_rsp_err=1, rdt=0.
REQ-025 i_rsp_ready held low 5 cycles while i_cmd_valid=1 -> rsp outputs stable, o_cmd_ready=0; the next command is accepted one cycle after the response handshake.
REQ-026 i_rst pulsed during the second BUS cycle -> cyc=0 after that edge, o_rsp_valid never asserts, o_cmd_ready=1 in the first cycle after reset is released.
